// File: rtl/motion_sequencer_if.sv
// Move-command bus for the motion sequencer.
//   cmd_valid_in / cmd_ready_out : command handshake (accept when both high)
//   cmd_steps_in                 : number of steps in the move
//   cmd_dir_in                   : direction of the move
//   start_period_in              : ramp start (slowest) period
//   min_period_in                : cruise (fastest) period
//   accel_in                     : period change per step while ramping
// master drives the command; slave is the sequencer.
interface motion_sequencer_if #(
    parameter int PERIOD_W = 64,
    parameter int COUNT_W  = 32
);
    logic                cmd_valid_in;
    logic                cmd_ready_out;
    logic [COUNT_W-1:0]  cmd_steps_in;
    logic                cmd_dir_in;
    logic [PERIOD_W-1:0] start_period_in;
    logic [PERIOD_W-1:0] min_period_in;
    logic [PERIOD_W-1:0] accel_in;

    modport master (
        output cmd_valid_in, cmd_steps_in, cmd_dir_in,
               start_period_in, min_period_in, accel_in,
        input  cmd_ready_out
    );

    modport slave (
        input  cmd_valid_in, cmd_steps_in, cmd_dir_in,
               start_period_in, min_period_in, accel_in,
        output cmd_ready_out
    );
endinterface

// File: rtl/motion_sequencer.sv
// Trapezoidal step-motion sequencer.
//   clk_in, reset_n_in : clock (rising edge), async active-low reset
//   cmd                : move-command bus (motion_sequencer_if.slave)
//   abort_in           : request a controlled stop (ramp down)
//   step_fb_in         : step pulse fed back from the motor driver
//   speed_out          : step period to the driver
//   step_enable_out    : step enable to the driver
//   dir_out            : direction to the driver
//   busy_out, done_out : move in progress / one-cycle completion pulse
//   steps_done_out     : steps counted in the current/last move
module motion_sequencer #(
    parameter int PERIOD_W = 64,
    parameter int COUNT_W  = 32
) (
    input  logic                clk_in,
    input  logic                reset_n_in,
    motion_sequencer_if.slave   cmd,
    input  logic                abort_in,
    input  logic                step_fb_in,
    output logic [PERIOD_W-1:0] speed_out,
    output logic                step_enable_out,
    output logic                dir_out,
    output logic                busy_out,
    output logic                done_out,
    output logic [COUNT_W-1:0]  steps_done_out
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCEL, CRUISE, DECEL, FINISH} state_t;

    state_t state, next_state;

    logic [PERIOD_W-1:0] start_q, min_q, accel_q;
    logic [COUNT_W-1:0]  remaining, a_cnt;
    logic                fb_prev;
    logic                fin_q;     // second FINISH cycle marker

    logic                accept, step, abort_hit;
    logic [COUNT_W-1:0]  rem_step, rem_next, a_step;
    logic [PERIOD_W-1:0] speed_step;

    assign accept = cmd.cmd_valid_in && cmd.cmd_ready_out;
    assign step   = step_fb_in && !fb_prev && step_enable_out;

    // Per-step arithmetic; abort is applied after the step so it sees
    // the updated remaining and ramp count.
    always_comb begin
        rem_step   = step ? remaining - 1'b1 : remaining;
        a_step     = a_cnt;
        speed_step = speed_out;
        if (step) begin
            if (state == ACCEL) begin
                a_step     = a_cnt + 1'b1;
                speed_step = (speed_out > min_q && speed_out - min_q > accel_q)
                             ? speed_out - accel_q : min_q;
            end else if (state == DECEL) begin
                a_step     = (a_cnt == '0) ? '0 : a_cnt - 1'b1;
                speed_step = (speed_out < start_q && start_q - speed_out > accel_q)
                             ? speed_out + accel_q : start_q;
            end
        end
        abort_hit = abort_in && (state == ACCEL || state == CRUISE);
        rem_next  = (abort_hit && rem_step > a_step) ? a_step : rem_step;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) state <= IDLE;
        else             state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (accept)
                        next_state = (cmd.cmd_steps_in == '0) ? FINISH : SETUP;
            SETUP:  next_state = ACCEL;
            ACCEL, CRUISE: begin
                if (rem_next == '0)
                    next_state = FINISH;
                else if (abort_hit || (step && rem_step <= a_step))
                    next_state = DECEL;
                else if (state == ACCEL && step && speed_step == min_q)
                    next_state = CRUISE;
            end
            DECEL:  if (rem_step == '0) next_state = FINISH;
            FINISH: if (fin_q) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FINISH spans two cycles: done pulses in the first, busy covers both.
    always_comb begin
        cmd.cmd_ready_out = (state == IDLE);
        step_enable_out   = (state == ACCEL || state == CRUISE || state == DECEL);
        busy_out          = (state != IDLE);
        done_out          = (state == FINISH) && !fin_q;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            start_q        <= '0;
            min_q          <= '0;
            accel_q        <= '0;
            remaining      <= '0;
            a_cnt          <= '0;
            speed_out      <= '0;
            dir_out        <= 1'b0;
            steps_done_out <= '0;
            fb_prev        <= 1'b0;
            fin_q          <= 1'b0;
        end else begin
            fb_prev <= step_fb_in;
            fin_q   <= (state == FINISH) && !fin_q;
            if (accept) begin
                start_q        <= cmd.start_period_in;
                min_q          <= cmd.min_period_in;
                accel_q        <= cmd.accel_in;
                remaining      <= cmd.cmd_steps_in;
                a_cnt          <= '0;
                speed_out      <= cmd.start_period_in;
                dir_out        <= cmd.cmd_dir_in;
                steps_done_out <= '0;
            end else begin
                remaining <= rem_next;
                a_cnt     <= a_step;
                speed_out <= speed_step;
                if (step) steps_done_out <= steps_done_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_motion_sequencer.sv
// Self-checking bench for motion_sequencer: table of moves plus
// hand-written sequences for zero-step, abort and mid-move reset.
module tb_motion_sequencer;

    localparam int PW = 64;
    localparam int CW = 32;

    logic          clk_in = 1'b0;
    logic          reset_n_in;
    logic          abort_in;
    logic          step_fb_in;
    logic [PW-1:0] speed_out;
    logic          step_enable_out;
    logic          dir_out;
    logic          busy_out;
    logic          done_out;
    logic [CW-1:0] steps_done_out;

    motion_sequencer_if #(.PERIOD_W(PW), .COUNT_W(CW)) cmd_bus ();

    motion_sequencer #(.PERIOD_W(PW), .COUNT_W(CW)) dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .cmd             (cmd_bus.slave),
        .abort_in        (abort_in),
        .step_fb_in      (step_fb_in),
        .speed_out       (speed_out),
        .step_enable_out (step_enable_out),
        .dir_out         (dir_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .steps_done_out  (steps_done_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        longint steps;
        bit     dir;
        longint start;
        longint min;
        longint acc;
        longint exp_speed;   // final speed_out after done
        longint exp_done;    // final steps_done_out
    } move_t;

    typedef struct {
        longint speed;
        longint done;
        bit     en;
    } exp_t;

    exp_t sb[$];

    // Behavioural model: 0 ACCEL, 1 CRUISE, 2 DECEL, 3 FINISH
    int     m_st;
    longint m_rem, m_a, m_speed, m_cnt, m_start, m_min, m_acc;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_step();
        m_cnt++;
        m_rem--;
        if (m_st == 0) begin
            m_a++;
            m_speed = (m_speed - m_min > m_acc) ? m_speed - m_acc : m_min;
        end else if (m_st == 2) begin
            if (m_a > 0) m_a--;
            m_speed = (m_start - m_speed > m_acc) ? m_speed + m_acc : m_start;
        end
        if (m_rem == 0)                            m_st = 3;
        else if (m_st <= 1 && m_rem <= m_a)        m_st = 2;
        else if (m_st == 0 && m_speed == m_min)    m_st = 1;
    endtask

    task automatic model_abort();
        if (m_st <= 1) begin
            if (m_rem > m_a) m_rem = m_a;
            m_st = (m_rem == 0) ? 3 : 2;
        end
    endtask

    task automatic apply_cmd(input longint steps, input bit dir, input longint start,
                             input longint min, input longint acc);
        @(negedge clk_in);
        for (int k = 0; k < 20 && !cmd_bus.cmd_ready_out; k++) @(negedge clk_in);
        check("ready_before_cmd", cmd_bus.cmd_ready_out, 1);
        cmd_bus.cmd_valid_in    = 1'b1;
        cmd_bus.cmd_steps_in    = CW'(steps);
        cmd_bus.cmd_dir_in      = dir;
        cmd_bus.start_period_in = PW'(start);
        cmd_bus.min_period_in   = PW'(min);
        cmd_bus.accel_in        = PW'(acc);
        @(negedge clk_in);
        cmd_bus.cmd_valid_in = 1'b0;
        check("dir_at_accept", dir_out, dir);
        check("speed_at_accept", speed_out, start);
        check("steps_done_cleared", steps_done_out, 0);
        check("enable_low_after_accept", step_enable_out, 0);
        check("busy_after_accept", busy_out, 1);
        m_st = (steps == 0) ? 3 : 0;
        m_rem = steps; m_a = 0; m_cnt = 0;
        m_speed = start; m_start = start; m_min = min; m_acc = acc;
    endtask

    task automatic pulse();
        exp_t e;
        model_step();
        e.speed = m_speed; e.done = m_cnt; e.en = (m_st != 3);
        sb.push_back(e);
        @(negedge clk_in);
        check("enable_before_step", step_enable_out, 1);
        step_fb_in = 1'b1;
        @(negedge clk_in);
        step_fb_in = 1'b0;
        e = sb.pop_front();
        check("step_speed", speed_out, e.speed);
        check("step_count", steps_done_out, e.done);
        check("step_enable", step_enable_out, e.en);
    endtask

    task automatic wait_done(input longint exp_cnt, input longint exp_speed);
        int dones = 0;
        for (int k = 0; k < 16 && busy_out; k++) begin
            if (done_out) dones++;
            @(negedge clk_in);
        end
        check("done_pulses", dones, 1);
        check("idle_after_done", busy_out, 0);
        check("final_steps_done", steps_done_out, exp_cnt);
        check("final_speed", speed_out, exp_speed);
        repeat (3) @(negedge clk_in);
        check("steps_done_held", steps_done_out, exp_cnt);
        check("no_stray_done", done_out, 0);
    endtask

    task automatic check_reset_values();
        check("rst_ready", cmd_bus.cmd_ready_out, 1);
        check("rst_speed", speed_out, 0);
        check("rst_enable", step_enable_out, 0);
        check("rst_dir", dir_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_steps_done", steps_done_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        move_t moves[4];
        int bc, dc;
        moves[0] = '{steps: 10, dir: 1'b0, start: 100, min: 40, acc: 20, exp_speed: 100, exp_done: 10};
        moves[1] = '{steps: 3,  dir: 1'b1, start: 100, min: 10, acc: 20, exp_speed: 80,  exp_done: 3};
        moves[2] = '{steps: 5,  dir: 1'b0, start: 50,  min: 30, acc: 25, exp_speed: 50,  exp_done: 5};
        moves[3] = '{steps: 1,  dir: 1'b1, start: 200, min: 100, acc: 50, exp_speed: 150, exp_done: 1};

        reset_n_in = 1'b0;
        abort_in   = 1'b0;
        step_fb_in = 1'b0;
        cmd_bus.cmd_valid_in    = 1'b0;
        cmd_bus.cmd_steps_in    = '0;
        cmd_bus.cmd_dir_in      = 1'b0;
        cmd_bus.start_period_in = '0;
        cmd_bus.min_period_in   = '0;
        cmd_bus.accel_in        = '0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk_in);
        reset_n_in = 1'b1;

        foreach (moves[i]) begin
            apply_cmd(moves[i].steps, moves[i].dir, moves[i].start, moves[i].min, moves[i].acc);
            for (longint s = 0; s < moves[i].steps; s++) pulse();
            wait_done(moves[i].exp_done, moves[i].exp_speed);
        end

        // Zero-step move: straight to FINISH, busy for two cycles.
        apply_cmd(0, 1'b1, 100, 40, 20);
        bc = 0; dc = 0;
        for (int k = 0; k < 10 && busy_out; k++) begin
            if (done_out) dc++;
            if (k == 0) check("zero_done_first_cycle", done_out, 1);
            check("zero_enable", step_enable_out, 0);
            bc++;
            @(negedge clk_in);
        end
        check("zero_busy_cycles", bc, 2);
        check("zero_done_pulses", dc, 1);
        check("zero_steps_done", steps_done_out, 0);

        // Abort in CRUISE with a=3, remaining=50.
        apply_cmd(60, 1'b0, 100, 40, 20);
        for (int s = 0; s < 10; s++) pulse();
        @(negedge clk_in);
        abort_in = 1'b1;
        model_abort();
        @(negedge clk_in);
        abort_in = 1'b0;
        check("abort_still_enabled", step_enable_out, 1);
        check("abort_steps_done", steps_done_out, 10);
        for (int s = 0; s < 3; s++) pulse();
        wait_done(13, 100);

        // Reset mid-ACCEL, then a normal move in the other direction.
        apply_cmd(20, 1'b1, 100, 40, 20);
        pulse();
        @(negedge clk_in);
        reset_n_in = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk_in);
        reset_n_in = 1'b1;
        check("no_done_after_reset", done_out, 0);
        apply_cmd(4, 1'b0, 100, 40, 20);
        for (int s = 0; s < 4; s++) pulse();
        wait_done(4, 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
